en_debounce: RTL and testbench
==============================

EN_DEBOUNCE -- requirements
Module: en_debounce

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive synchronized cycles a new level must persist before it is accepted; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8: debounce counter width; must hold DEB_CYCLES-1.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ena, input, 1: high = counters advance; low = debounce state frozen.
REQ-006 SHALL have port raw1, input, 1: asynchronous raw enable request, channel 1.
REQ-007 SHALL have port raw2, input, 1: asynchronous raw enable request, channel 2.
REQ-008 SHALL have port en1, output, 1: registered debounced level, channel 1; feeds the downstream en1 combiner input.
REQ-009 SHALL have port en2, output, 1: registered debounced level, channel 2; feeds the downstream en2 combiner input.
REQ-010 SHALL have port rise1, output, 1: one-cycle pulse when en1 goes 0->1.
REQ-011 SHALL have port rise2, output, 1: one-cycle pulse when en2 goes 0->1.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer; the second flop output is "s".
REQ-013 Each channel SHALL run a 4-state FSM: ST_LO, CHK_HI, ST_HI, CHK_LO.
REQ-014 ST_LO: s=1 -> CHK_HI, counter cleared to 0; else stay.
REQ-015 CHK_HI: s=0 -> ST_LO, counter cleared, en unchanged; s=1 and counter=DEB_CYCLES-1 -> ST_HI with en set to 1 on the same edge; otherwise counter+1.
REQ-016 ST_HI and CHK_LO SHALL mirror REQ-014/REQ-015 with levels inverted; en is cleared to 0 on entry to ST_LO from CHK_LO.
REQ-017 With ena=1 and raw held constant, en SHALL change exactly DEB_CYCLES+2 rising edges after the first edge that samples the new raw level.
REQ-018 A pulse of the opposite level lasting fewer than DEB_CYCLES synchronized cycles SHALL produce no change on en or rise.
REQ-019 With ena=0, FSM state, counter and en SHALL hold; the synchronizer SHALL keep sampling; on return to ena=1 the FSM evaluates the current s.
REQ-020 The counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-021 rise SHALL be high for exactly one cycle, on the same cycle en first reads 1; it SHALL NOT assert on 1->0 transitions.
REQ-022 The channels SHALL be fully independent; simultaneous changes with equal timing SHALL produce same-cycle en1/en2 and rise1/rise2 changes.

Reset
REQ-023 rst_n low SHALL immediately clear both synchronizer flops, counters, en1, en2, rise1 and rise2 to 0 and force both FSMs to ST_LO, including mid-CHK_HI or mid-CHK_LO.
REQ-024 After rst_n deasserts, a raw input already high SHALL be accepted per REQ-017 from the first post-reset edge.

Configuration
REQ-025 Macro EN_DEBOUNCE_RISE_EN defined: rise1/rise2 SHALL behave per REQ-021.
REQ-026 Macro EN_DEBOUNCE_RISE_EN undefined: rise1/rise2 SHALL be tied to 0 and the edge-detect logic SHALL be omitted; en1/en2 behaviour is unchanged.

Structure
REQ-027 A shared package en_debounce_pkg SHALL hold the FSM state typedef (ST_LO, CHK_HI, ST_HI, CHK_LO) and the default DEB_CYCLES constant.
REQ-028 One sub-module, en_debounce_ch (synchronizer, FSM, counter and rise for one channel), SHALL be instantiated twice.

Verification (DEB_CYCLES=4, ena=1 unless stated)
REQ-029 raw1 0->1 sampled at edge 0 and held -> en1=1 and rise1=1 at edge 6; rise1=0 at edge 7; en2 stays 0.
REQ-030 raw1 high for 3 cycles then low -> en1 and rise1 stay 0 throughout.
REQ-031 raw1 and raw2 rise at the same edge -> en1 and en2 rise together at edge 6; a later raw2 fall held 6 edges -> en2=0 with no rise2 pulse.
REQ-032 rst_n pulsed low during CHK_HI (counter=2) -> all outputs 0 at once; raw1 still high -> en1 rises 6 edges after reset release.
REQ-033 ena=0 for 5 cycles during CHK_HI -> en1 delayed by exactly 5 cycles, i.e. rises at edge 11.
REQ-034 Build without EN_DEBOUNCE_RISE_EN and rerun REQ-029 -> en1 timing identical; rise1 constantly 0.

Source files
------------

// File: rtl/en_debounce_pkg.sv
// en_debounce_pkg: shared types and defaults for the enable debouncer.
//   deb_state_e      - per-channel debounce FSM state encoding
//   DEB_CYCLES_DEF   - default number of stable synchronized cycles
//   CNT_W_DEF        - default debounce counter width
package en_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } deb_state_e;

    localparam int unsigned DEB_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 8;

endpackage

// File: rtl/en_debounce_ch.sv
// en_debounce_ch: one debounce channel (2-flop synchronizer, 4-state FSM,
// stability counter, optional rising-edge pulse).
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   ena_i   - 1: FSM/counter advance, 0: debounce state frozen
//   raw_i   - asynchronous raw level
//   en_o    - registered debounced level
//   rise_o  - one-cycle pulse on en_o 0->1 (tied 0 unless EN_DEBOUNCE_RISE_EN)
// Configuration macro: EN_DEBOUNCE_RISE_EN
module en_debounce_ch
    import en_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ena_i,
    input  logic raw_i,
    output logic en_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;

    // Synchronizer keeps sampling regardless of ena_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        if (ena_i) begin
            case (state_q)
                ST_LO: begin
                    if (s) begin
                        state_d = CHK_HI;
                        cnt_d   = '0;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        en_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state_d = CHK_LO;
                        cnt_d   = '0;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                        en_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign en_o = en_q;

`ifdef EN_DEBOUNCE_RISE_EN
    logic rise_q, rise_d;

    // Fires on the same edge that sets en, so rise and en read 1 together.
    always_comb begin
        rise_d = ena_i && (state_q == CHK_HI) && s && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;
`else
    assign rise_o = 1'b0;
`endif

endmodule

// File: rtl/en_debounce.sv
// en_debounce: two independent debounced enable channels.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   ena    - 1: debounce counters advance, 0: frozen
//   raw1/2 - asynchronous raw enable requests
//   en1/2  - registered debounced levels
//   rise1/2- one-cycle pulse on en 0->1
// Configuration macro: EN_DEBOUNCE_RISE_EN (rise1/rise2 tied 0 when undefined)
module en_debounce
    import en_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw1,
    input  logic raw2,
    output logic en1,
    output logic en2,
    output logic rise1,
    output logic rise2
);

    en_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ena_i  (ena),
        .raw_i  (raw1),
        .en_o   (en1),
        .rise_o (rise1)
    );

    en_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ena_i  (ena),
        .raw_i  (raw2),
        .en_o   (en2),
        .rise_o (rise2)
    );

endmodule

// File: tb/tb_en_debounce.sv
module tb_en_debounce;

    logic clk;
    logic rst_n;
    logic ena;
    logic raw1;
    logic raw2;
    logic en1;
    logic en2;
    logic rise1;
    logic rise2;

    int errors = 0;
    int checks = 0;

`ifdef EN_DEBOUNCE_RISE_EN
    localparam logic RISE_ON = 1'b1;
`else
    localparam logic RISE_ON = 1'b0;
`endif

    en_debounce #(
        .DEB_CYCLES (4),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .raw1  (raw1),
        .raw2  (raw2),
        .en1   (en1),
        .en2   (en2),
        .rise1 (rise1),
        .rise2 (rise2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit after the last one.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        raw1  = 1'b0;
        raw2  = 1'b0;
        #12;
        chk("rst_en1", en1, 1'b0);
        chk("rst_en2", en2, 1'b0);
        chk("rst_rise1", rise1, 1'b0);
        chk("rst_rise2", rise2, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Single channel rise: next edge is edge 0
        raw1 = 1'b1;
        step(6);
        chk("r29_en1_e5", en1, 1'b0);
        step(1);
        chk("r29_en1_e6", en1, 1'b1);
        chk("r29_rise1_e6", rise1, RISE_ON);
        chk("r29_en2_e6", en2, 1'b0);
        step(1);
        chk("r29_en1_e7", en1, 1'b1);
        chk("r29_rise1_e7", rise1, 1'b0);
        chk("r29_rise2_e7", rise2, 1'b0);

        // Fall also takes 6 edges, no rise pulse
        raw1 = 1'b0;
        step(6);
        chk("fall_en1_e5", en1, 1'b1);
        step(1);
        chk("fall_en1_e6", en1, 1'b0);
        chk("fall_rise1_e6", rise1, 1'b0);
        step(3);

        // Glitch: 3 cycles high is rejected
        raw1 = 1'b1;
        step(3);
        raw1 = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            chk("glitch_en1", en1, 1'b0);
            chk("glitch_rise1", rise1, 1'b0);
            step(1);
        end

        // Both channels together
        raw1 = 1'b1;
        raw2 = 1'b1;
        step(6);
        chk("both_en1_e5", en1, 1'b0);
        chk("both_en2_e5", en2, 1'b0);
        step(1);
        chk("both_en1_e6", en1, 1'b1);
        chk("both_en2_e6", en2, 1'b1);
        chk("both_rise1_e6", rise1, RISE_ON);
        chk("both_rise2_e6", rise2, RISE_ON);
        step(2);
        raw2 = 1'b0;
        step(6);
        chk("r2fall_en2_e5", en2, 1'b1);
        step(1);
        chk("r2fall_en2_e6", en2, 1'b0);
        chk("r2fall_rise2_e6", rise2, 1'b0);
        chk("r2fall_en1_e6", en1, 1'b1);
        raw1 = 1'b0;
        step(10);
        chk("idle_en1", en1, 1'b0);

        // Reset mid CHK_HI with en2 high
        raw2 = 1'b1;
        step(8);
        chk("pre_rst_en2", en2, 1'b1);
        raw1 = 1'b1;
        step(5);  // after edge 4: channel 1 in CHK_HI, counter=2
        chk("pre_rst_en1", en1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en1", en1, 1'b0);
        chk("async_rst_en2", en2, 1'b0);
        chk("async_rst_rise1", rise1, 1'b0);
        chk("async_rst_rise2", rise2, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(6);
        chk("post_rst_en1_e5", en1, 1'b0);
        chk("post_rst_en2_e5", en2, 1'b0);
        step(1);
        chk("post_rst_en1_e6", en1, 1'b1);
        chk("post_rst_en2_e6", en2, 1'b1);
        chk("post_rst_rise1_e6", rise1, RISE_ON);
        raw1 = 1'b0;
        raw2 = 1'b0;
        step(10);
        chk("idle2_en1", en1, 1'b0);
        chk("idle2_en2", en2, 1'b0);

        // ena=0 for 5 edges during CHK_HI delays acceptance by 5
        raw1 = 1'b1;
        step(3);  // after edge 2: CHK_HI counter=0
        ena = 1'b0;
        step(5);  // edges 3..7 frozen
        chk("frz_en1_e7", en1, 1'b0);
        ena = 1'b1;
        step(3);
        chk("frz_en1_e10", en1, 1'b0);
        step(1);
        chk("frz_en1_e11", en1, 1'b1);
        chk("frz_rise1_e11", rise1, RISE_ON);
        step(1);
        chk("frz_rise1_e12", rise1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
